// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and default UART reply bytes for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_ACK,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - UART byte, instruction-memory and core-control bundle for the program loader
interface loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        loading;
  logic        err;

  // The loader itself
  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, imem_we, imem_addr, imem_wdata, core_rst, loading, err
  );

  // UART, instruction memory and core surrounding the loader
  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, imem_we, imem_addr, imem_wdata, core_rst, loading, err
  );
endinterface

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs four strobed bytes into a little-endian 32-bit word
module byte_assembler (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  cnt;
  logic [23:0] low_bytes;

  // The 4th byte completes the word in the same cycle so the caller can register it directly
  assign word_valid = in_valid && (cnt == 2'd3);
  assign word_data  = {in_data, low_bytes};

  // Collect the three low bytes; the counter wraps 3->0 as each word completes
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt       <= 2'd0;
      low_bytes <= 24'd0;
    end else if (in_valid) begin
      case (cnt)
        2'd0:    low_bytes[7:0]   <= in_data;
        2'd1:    low_bytes[15:8]  <= in_data;
        2'd2:    low_bytes[23:16] <= in_data;
        default: low_bytes        <= low_bytes;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: UART image to instruction memory, then ACK and core release
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16384,
  parameter logic [7:0]  ACK_BYTE   = DEFAULT_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE   = DEFAULT_ERR_BYTE
) (
  input  logic clk,
  input  logic rst,
  loader_if.master bus
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] word_cnt;
  logic [31:0] word_idx;
  logic        err_sent;
  logic        asm_in_valid;
  logic        word_valid;
  logic [31:0] asm_word;
  logic        tx_fire;

  assign tx_fire = bus.tx_valid && bus.tx_ready;

  // Bytes only reach the assembler while a length or a still-expected data word is being received
  assign asm_in_valid = bus.rx_valid &&
                        ((state == S_LEN) || ((state == S_DATA) && (word_idx != word_cnt)));

  byte_assembler u_asm (
    .clk        (clk),
    .clr        (rst),
    .in_valid   (asm_in_valid),
    .in_data    (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (asm_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LEN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; S_DATA leaves one cycle after the final write, once the index has reached N
  always_comb begin
    state_nx = state;
    case (state)
      S_LEN: begin
        if (word_valid) begin
          if (asm_word > 32'(IMEM_WORDS)) begin
            state_nx = S_ERR;
          end else if (asm_word == 32'd0) begin
            state_nx = S_ACK;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_idx == word_cnt) begin
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_fire) begin
          state_nx = S_RUN;
        end
      end
      S_RUN:   state_nx = S_RUN;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_LEN;
    endcase
  end

  // Registered outputs, word index and the TX holding register, all derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= 32'd0;
      bus.imem_wdata <= 32'd0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= 8'd0;
      bus.core_rst   <= 1'b1;
      bus.loading    <= 1'b0;
      bus.err        <= 1'b0;
      word_cnt       <= 32'd0;
      word_idx       <= 32'd0;
      err_sent       <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if ((state == S_LEN) && word_valid) begin
        word_cnt <= asm_word;
        word_idx <= 32'd0;
      end
      if ((state == S_DATA) && word_valid) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= {word_idx[29:0], 2'b00};
        bus.imem_wdata <= asm_word;
        word_idx       <= word_idx + 32'd1;
      end
      if (state_nx == S_ACK) begin
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= ACK_BYTE;
      end else if ((state_nx == S_ERR) && !err_sent && !tx_fire) begin
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= ERR_BYTE;
      end else begin
        bus.tx_valid <= 1'b0;
      end
      if ((state == S_ERR) && tx_fire) begin
        err_sent <= 1'b1;
      end
      bus.core_rst <= (state_nx != S_RUN);
      bus.loading  <= (state_nx == S_LEN) || (state_nx == S_DATA);
      bus.err      <= (state_nx == S_ERR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int unsigned TB_WORDS = 16;
  localparam logic [7:0]  ACK_B    = 8'hAA;
  localparam logic [7:0]  ERR_B    = 8'hEE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  loader_if lif();

  program_loader #(
    .IMEM_WORDS (TB_WORDS),
    .ACK_BYTE   (ACK_B),
    .ERR_BYTE   (ERR_B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          we_double = 0;
  logic        prev_we = 1'b0;

  // Observe memory writes and completed TX handshakes away from the active edge
  always @(negedge clk) begin
    if (lif.imem_we) wr_q.push_back({lif.imem_addr, lif.imem_wdata});
    if (lif.imem_we && prev_we) we_double <= we_double + 1;
    prev_we <= lif.imem_we;
    if (lif.tx_valid && lif.tx_ready) tx_q.push_back(lif.tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    lif.rx_valid = 1'b1;
    lif.rx_data  = b;
    tick();
    lif.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      put_byte(w[8*k +: 8]);
      if (gap > 0) repeat ($urandom_range(gap, 0)) tick();
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'd0;
    lif.tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_q.delete();
    tx_q.delete();
    we_double = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!lif.core_rst) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] got8;
    rst          = 1'b1;
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'd0;
    lif.tx_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({lif.imem_we, lif.imem_addr, lif.imem_wdata, lif.tx_valid, lif.tx_data} !== 74'd0) begin
      errors++;
      $display("FAIL reset_datapath: got we=%b addr=%h wdata=%h txv=%b txd=%h, expected all zero",
               lif.imem_we, lif.imem_addr, lif.imem_wdata, lif.tx_valid, lif.tx_data);
    end
    got8 = {5'd0, lif.core_rst, lif.loading, lif.err};
    checks++;
    if (got8 !== 8'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got core_rst/loading/err=%b expected 100", got8[2:0]);
    end
    rst = 1'b0;
    @(negedge clk);
    got8 = {5'd0, lif.core_rst, lif.loading, lif.err};
    checks++;
    if (got8 !== 8'b110) begin
      errors++;
      $display("FAIL reset_release: got core_rst/loading/err=%b expected 110", got8[2:0]);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] exp[$];
    bit ok, same;
    do_reset();
    exp = '{{32'd0, 32'h00000013}, {32'd4, 32'hDEADBEEF}};
    send_word(32'd2, 2);
    send_word(32'h00000013, 2);
    send_word(32'hDEADBEEF, 2);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: core_rst never fell"); end
    same = (wr_q.size() == exp.size());
    foreach (exp[i]) if (same && wr_q[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin errors++; $display("FAIL basic_writes: got %0d writes (first %h) expected %0d", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'd0, exp.size()); end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK_B) begin errors++; $display("FAIL basic_ack: got %0d tx bytes (first %h) expected one %h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, ACK_B); end
    checks++;
    if ({lif.core_rst, lif.loading, lif.err} !== 3'b000) begin errors++; $display("FAIL basic_run: got core_rst/loading/err=%b expected 000", {lif.core_rst, lif.loading, lif.err}); end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_word(32'd0, 1);
    @(negedge clk);
    checks++;
    if ({lif.tx_valid, lif.tx_data, lif.core_rst} !== {1'b1, ACK_B, 1'b1}) begin
      errors++;
      $display("FAIL zero_ack: got txv=%b txd=%h core_rst=%b expected 1 %h 1", lif.tx_valid, lif.tx_data, lif.core_rst, ACK_B);
    end
    @(negedge clk);
    checks++;
    if ({lif.tx_valid, lif.core_rst} !== 2'b00) begin
      errors++;
      $display("FAIL zero_release: got txv=%b core_rst=%b expected 0 0", lif.tx_valid, lif.core_rst);
    end
    tick();
    checks++;
    if (wr_q.size() != 0 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL zero_side: got %0d writes %0d tx bytes expected 0 and 1", wr_q.size(), tx_q.size());
    end
  endtask

  task automatic test_err();
    do_reset();
    send_word(32'(TB_WORDS + 1), 1);
    @(negedge clk);
    checks++;
    if ({lif.err, lif.core_rst, lif.loading} !== 3'b110) begin
      errors++;
      $display("FAIL err_rise: got err/core_rst/loading=%b expected 110", {lif.err, lif.core_rst, lif.loading});
    end
    tick();
    for (int k = 0; k < 8; k++) put_byte(8'($urandom));
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== ERR_B) begin
      errors++;
      $display("FAIL err_tx: got %0d writes %0d tx bytes (first %h) expected 0 writes one %h", wr_q.size(), tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, ERR_B);
    end
    checks++;
    if ({lif.err, lif.core_rst, lif.tx_valid} !== 3'b110) begin
      errors++;
      $display("FAIL err_hold: got err/core_rst/tx_valid=%b expected 110", {lif.err, lif.core_rst, lif.tx_valid});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    logic [63:0] exp[$];
    bit ok, same;
    do_reset();
    w0 = $urandom;
    w1 = $urandom;
    exp = '{{32'd0, w0}, {32'd4, w1}};
    send_word(32'd2, 0);
    send_word(w0, 0);
    send_word(w1, 0);
    @(negedge clk);
    checks++;
    if ({lif.imem_we, lif.imem_addr, lif.imem_wdata, lif.tx_valid} !== {1'b1, 32'd4, w1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_last_write: got we=%b addr=%h data=%h txv=%b expected 1 4 %h 0", lif.imem_we, lif.imem_addr, lif.imem_wdata, lif.tx_valid, w1);
    end
    @(negedge clk);
    checks++;
    if ({lif.tx_valid, lif.core_rst} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_ack_rise: got txv=%b core_rst=%b expected 1 1", lif.tx_valid, lif.core_rst);
    end
    wait_done(ok);
    same = ok && (wr_q.size() == exp.size()) && (we_double == 0);
    foreach (exp[i]) if (same && wr_q[i] !== exp[i]) same = 1'b0;
    checks++;
    if (!same) begin errors++; $display("FAIL b2b_writes: got %0d writes (last %h) double=%0d expected %0d", wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 64'd0, we_double, exp.size()); end
  endtask

  task automatic test_tx_stall();
    bit seen;
    do_reset();
    lif.tx_ready = 1'b0;
    send_word(32'd1, 0);
    send_word(32'hCAFE0001, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lif.tx_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_txv: got tx_valid=0 expected 1 within 20 cycles"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({lif.tx_valid, lif.tx_data, lif.core_rst} !== {1'b1, ACK_B, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold: got txv=%b txd=%h core_rst=%b expected 1 %h 1", lif.tx_valid, lif.tx_data, lif.core_rst, ACK_B);
      end
    end
    tick();
    lif.tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (lif.core_rst !== 1'b1) begin errors++; $display("FAIL stall_hs_cycle: got core_rst=%b expected 1", lif.core_rst); end
    @(negedge clk);
    checks++;
    if ({lif.core_rst, lif.tx_valid} !== 2'b00) begin errors++; $display("FAIL stall_release: got core_rst=%b txv=%b expected 0 0", lif.core_rst, lif.tx_valid); end
    checks++;
    if (tx_q.size() != 1) begin errors++; $display("FAIL stall_once: got %0d tx bytes expected 1", tx_q.size()); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send_word(32'd2, 0);
    send_word(32'hA1B2C3D4, 0);
    put_byte(8'h55);
    put_byte(8'h66);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_q.delete();
    tx_q.delete();
    send_word(32'd1, 1);
    send_word(32'h12345678, 1);
    wait_done(ok);
    checks++;
    if (!ok || wr_q.size() != 1 || wr_q[0] !== {32'd0, 32'h12345678}) begin
      errors++;
      $display("FAIL reset_mid: got done=%b %0d writes (first %h) expected one 00000000_12345678", ok, wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'd0);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int unsigned n;
      int gap;
      logic [31:0] w;
      logic [63:0] exp[$];
      bit ok, same;
      n   = (it == 0) ? TB_WORDS : $urandom_range(TB_WORDS, 1);
      gap = it % 3;
      exp.delete();
      do_reset();
      send_word(32'(n), gap);
      for (int unsigned i = 0; i < n; i++) begin
        w = $urandom;
        exp.push_back({32'(4 * i), w});
        send_word(w, gap);
      end
      wait_done(ok);
      same = ok && (wr_q.size() == exp.size()) && (we_double == 0);
      foreach (exp[i]) if (same && wr_q[i] !== exp[i]) same = 1'b0;
      checks++;
      if (!same) begin errors++; $display("FAIL random_load[%0d]: got done=%b %0d writes double=%0d expected %0d writes", it, ok, wr_q.size(), we_double, n); end
      checks++;
      if (tx_q.size() != 1 || tx_q[0] !== ACK_B || lif.err !== 1'b0) begin errors++; $display("FAIL random_ack[%0d]: got %0d tx bytes err=%b expected one %h", it, tx_q.size(), lif.err, ACK_B); end
    end
  endtask

  initial begin
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'd0;
    lif.tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_err();
    test_back_to_back();
    test_tx_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
